// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared ALU opcodes, default widths and id width helper
package alu_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int OP_W_DEF    = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: rotate by pointer, priority encode
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = id_width(NUM_REQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_grant
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // rot[k] is requester (ptr + k) mod N, so the lowest set bit is the next in turn.
  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    int off;
    int sum;
    off       = 0;
    sum       = 0;
    any_grant = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off       = k;
        any_grant = 1'b1;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    idx   = IW'(sum);
    grant = any_grant ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU with a registered response
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ID_W    = id_width(NUM_REQ_DEF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic [31:0]               alu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [31:0]               rsp_flags
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               can_accept;
  logic               xfer;

  assign can_accept = !rsp_valid || rsp_ready;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_grant (pick_any)
  );

  assign req_ready = (rst_n && can_accept) ? pick_grant : '0;
  assign xfer      = pick_any && can_accept;

  // The winner drives the ALU even when stalled; idle cycles drive zeros, never X.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (pick_any) begin
      alu_a  = req_a[int'(pick_idx)*DATA_W +: DATA_W];
      alu_b  = req_b[int'(pick_idx)*DATA_W +: DATA_W];
      alu_op = req_op[int'(pick_idx)*OP_W +: OP_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= pick_idx;
      rsp_data  <= alu_out;
      rsp_flags <= alu_flags;
      rr_ptr    <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with reference ALU and arbiter model
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*OW-1:0] req_op;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [OW-1:0]    alu_op;
  logic [DW-1:0]    alu_out;
  logic [31:0]      alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [DW-1:0]    rsp_data;
  logic [31:0]      rsp_flags;

  logic          rv [NR];
  logic [DW-1:0] ra [NR];
  logic [DW-1:0] rb [NR];
  logic [OW-1:0] rop[NR];

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [31:0]   flags;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags)
  );

  // Reference ALU: {flags, result}; flags bit1 = zero, bit0 = carry/borrow.
  function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    w = '0;
    r = '0;
    c = 1'b0;
    case (op)
      ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
      ALU_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      default: r = {31'b0, $signed(a) < $signed(b)};
    endcase
    return {30'b0, (r == 32'b0), c, r};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = alu_ref(alu_a, alu_b, alu_op);
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = rv[i];
      req_a[i*DW +: DW]      = ra[i];
      req_b[i*DW +: DW]      = rb[i];
      req_op[i*OW +: OW]     = rop[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters must hold valid and operands until accepted.
  logic [NR-1:0] hold;
  logic [DW-1:0] h_a [NR];
  logic [DW-1:0] h_b [NR];
  logic [OW-1:0] h_op[NR];
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst_n && hold[i])
        assert (rv[i] && ra[i] == h_a[i] && rb[i] == h_b[i] && rop[i] == h_op[i])
          else $error("protocol violation: requester %0d dropped or changed before acceptance", i);
      hold[i] <= rst_n && rv[i] && !req_ready[i];
      h_a[i]  <= ra[i];
      h_b[i]  <= rb[i];
      h_op[i] <= rop[i];
    end
  end

  // Reference arbiter: plain round-robin scan over the pending requests.
  int   m_ptr = 0;
  bit   m_rv  = 0;
  int   m_wait[NR];
  always @(negedge clk) begin
    bit   can;
    bit   found;
    int   w;
    exp_t e;
    if (!rst_n) begin
      m_ptr = 0;
      m_rv  = 0;
      exp_q.delete();
      for (int i = 0; i < NR; i++) m_wait[i] = 0;
      chk("ready_in_reset", 64'(req_ready), 64'd0);
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      can   = !m_rv || rsp_ready;
      found = 0;
      w     = 0;
      for (int j = 0; j < NR; j++) begin
        if (!found && rv[(m_ptr + j) % NR]) begin
          found = 1;
          w     = (m_ptr + j) % NR;
        end
      end
      chk("req_ready", 64'(req_ready), (found && can) ? (64'd1 << w) : 64'd0);
      if (found) begin
        chk("alu_a", 64'(alu_a), 64'(ra[w]));
        chk("alu_b", 64'(alu_b), 64'(rb[w]));
        chk("alu_op", 64'(alu_op), 64'(rop[w]));
      end else begin
        chk("alu_idle", {29'b0, alu_op, alu_a | alu_b}, 64'd0);
      end
      if (found && can) begin
        e.id = IW'(w);
        {e.flags, e.data} = alu_ref(ra[w], rb[w], rop[w]);
        exp_q.push_back(e);
        chk("fairness_wait", 64'(m_wait[w] <= NR - 1), 64'd1);
        for (int i = 0; i < NR; i++) if (rv[i] && i != w) m_wait[i]++;
        m_wait[w] = 0;
        m_ptr = (w + 1) % NR;
        m_rv  = 1;
      end else if (m_rv && rsp_ready) begin
        m_rv = 0;
      end
    end
  end

  // Monitor: the presented response must match the oldest expectation until consumed.
  always @(negedge clk) begin
    exp_t h;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        h = exp_q[0];
        chk("rsp_id", 64'(rsp_id), 64'(h.id));
        chk("rsp_data", 64'(rsp_data), 64'(h.data));
        chk("rsp_flags", 64'(rsp_flags), 64'(h.flags));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    rv[i]  = 1'b1;
    ra[i]  = a;
    rb[i]  = b;
    rop[i] = op;
  endtask

  task automatic new_rand(input int i);
    logic [DW-1:0] a;
    a = $urandom;
    set_req(i, a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom), OW'($urandom_range(0, 7)));
  endtask

  task automatic step_rand(input bit allow_new);
    logic [NR-1:0] acc;
    neg();
    acc = req_valid & req_ready;
    tick();
    rsp_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] || !rv[i]) begin
        if (allow_new && $urandom_range(0, 2) != 0) new_rand(i);
        else rv[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, DW'(i), '0, ALU_ADD);
    set_req(1, 32'ha47b_a47b, 32'h5c91_5c91, ALU_ADD);
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    repeat (2) neg();
    tick();
    rst_n = 1'b1;

    // All requesters valid: grants rotate 0,1,2,3,0 without bubbles.
    for (int k = 0; k < 5; k++) begin
      neg();
      chk("rr_order", 64'(req_ready), 64'd1 << (k % NR));
      if (k == 2) begin
        chk("add_req1_id", 64'(rsp_id), 64'd1);
        chk("add_req1_data", 64'(rsp_data), 64'h010d_010c);
      end
      tick();
      if (k == 4) rv[0] = 1'b0;
    end
    for (int k = 1; k < NR; k++) begin
      neg();
      chk("rr_order_tail", 64'(req_ready), 64'd1 << k);
      tick();
      rv[k] = 1'b0;
    end

    // Single requester 2.
    set_req(2, 32'hffff_ffff, 32'h0, ALU_ADD);
    neg();
    chk("single_grant", 64'(req_ready), 64'b0100);
    tick();
    rv[2] = 1'b0;
    neg();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_data", 64'(rsp_data), 64'hffff_ffff);
    tick();
    neg();
    chk("single_drained", 64'(rsp_valid), 64'd0);

    // Wrap-around: last grant 3, then 0 and 2 valid.
    tick();
    set_req(3, 32'd5, 32'd6, ALU_ADD);
    neg();
    chk("wrap_grant3", 64'(req_ready), 64'b1000);
    tick();
    rv[3] = 1'b0;
    set_req(0, 32'd9, 32'd4, ALU_SUB);
    set_req(2, 32'd100, 32'd23, ALU_ADD);
    neg();
    chk("wrap_first", 64'(req_ready), 64'b0001);
    tick();
    rv[0] = 1'b0;
    neg();
    chk("wrap_second", 64'(req_ready), 64'b0100);
    tick();
    rv[2] = 1'b0;

    // Backpressure on the held req 2 response.
    rsp_ready = 1'b0;
    new_rand(1);
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd2);
      chk("bp_data", 64'(rsp_data), 64'd123);
      tick();
    end
    rsp_ready = 1'b1;
    neg();
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    chk("bp_release_valid", 64'(rsp_valid), 64'd1);
    tick();
    rv[1] = 1'b0;
    neg();
    chk("bp_next_id", 64'(rsp_id), 64'd1);
    tick();

    // Reset while a response is held under backpressure.
    set_req(0, 32'd7, 32'd8, ALU_ADD);
    neg();
    chk("mid_grant", 64'(req_ready), 64'b0001);
    tick();
    rv[0]     = 1'b0;
    rsp_ready = 1'b0;
    neg();
    chk("mid_held", 64'(rsp_data), 64'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_data", 64'(rsp_data), 64'd0);
    repeat (2) neg();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      neg();
      chk("no_replay", 64'(rsp_valid), 64'd0);
    end
    tick();

    repeat (3000) step_rand(1'b1);
    repeat (20) step_rand(1'b0);
    neg();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (ports out, flags, a, b, op) among NUM_REQ requesters, such as the address-generation, execute and microcode-sequencer stages.
- Uses round-robin arbitration with valid/ready handshakes on both sides.
- Registers each ALU result with its requester ID into a single output stage.
- Sits between the pipeline stages and the alu instance. It owns that instance's input muxing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 3, ALU opcode width.
- ID_W, 2, width of the requester index; equals clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit high
- req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand B
- req_op  in  NUM_REQ*OP_W  packed opcode
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- alu_op  out  OP_W  to ALU op
- alu_out  in  DATA_W  from ALU out
- alu_flags  in  32  from ALU flags
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  ID_W  index of the requester that produced the response
- rsp_data  out  DATA_W  registered ALU result
- rsp_flags  out  32  registered ALU flags

Behaviour:
- Clocking and reset: clk is the only clock. rst_n is asynchronous and active-low; assertion immediately clears all state.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Accept condition: can_accept = !rsp_valid | rsp_ready. This is a single-entry pipeline register with no skid buffer.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping NUM_REQ-1 -> 0.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner, and only when can_accept=1.
- ALU drive:
  - With a winner: alu_a/alu_b/alu_op = the winner's fields.
  - Without a winner: drive 0/0/0, so the ALU never sees X.
  - The ALU is purely combinational; its result is sampled in the same cycle as the grant.
- Transfer: a transfer occurs on req_valid[i] & req_ready[i]. At that posedge:
  - rsp_data<=alu_out, rsp_flags<=alu_flags, rsp_id<=i, rsp_valid<=1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: 1 cycle from grant to rsp_valid. Throughput is 1 op/cycle while rsp_ready=1.
- Response drain without a new grant: rsp_valid & rsp_ready & no transfer -> rsp_valid<=0; the other rsp_* fields hold their values.
- Simultaneous drain and grant: the new result overwrites the register and rsp_valid stays 1. No bubble.
- Backpressure: rsp_valid=1 & rsp_ready=0 -> all rsp_* outputs are held stable, all req_ready=0, and rr_ptr is unchanged.
- No request: rr_ptr is unchanged.
- Fairness: a continuously-valid requester is granted within NUM_REQ accept cycles.
- Requester protocol:
  - Once req_valid[i] is asserted, it and its operands are held until accepted.
  - Dropping valid before acceptance is a protocol violation; the bench flags it with an assertion and the RTL need not handle it.
- Reset mid-operation: any held response is discarded (rsp_valid->0). No result is replayed.

Decomposition:
- Package alu_arb_pkg holds:
  - ALU opcode constants: ALU_ADD=3'b000, plus the remaining op encodings.
  - Default NUM_REQ/DATA_W/OP_W.
  - A function computing ID_W.
- Sub-module rr_pick (purely combinational):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, encoded index and any_grant.
  - Implemented via a double-width vector rotate and priority encode.
- Top-level alu_arbiter contains the operand muxes, the response register and rr_ptr. The alu itself is instantiated outside, by the integrating stage.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_* all zero. Release rst_n -> requester 0 is granted first (rr_ptr=0).
- Single requester: req 2 sends a=32'hffff_ffff, b=0, op=ADD with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, rsp_data=32'hffff_ffff. The following cycle rsp_valid=0.
- All four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0. Back-to-back rsp_valid with no bubbles. Use a=32'ha47ba47b, b=32'h5c915c91 for req 1 -> rsp_data=32'h010d010c.
- Backpressure: hold rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_data/id/flags are stable and req_ready=0. Raise rsp_ready -> the next requester is granted in that same cycle and rsp_valid stays 1.
- Wrap-around: last grant was req 3, then only req 0 and req 2 are valid -> req 0 is granted before req 2. rr_ptr goes 0 -> 1 -> 3.
- Reset mid-operation: assert rst_n=0 asynchronously while rsp_valid=1 and rsp_ready=0 -> rsp_valid drops immediately without waiting for clk. No response is emitted after release until a new request arrives.
